dmem_store_buffer: RTL

- Data memory for the pipelined core's Memory stage, sitting directly downstream of the core.
- Consumes the core's M-stage address, store data and store enable; returns load data combinationally in the same cycle, for capture into the W register.
- Stores are posted into a small FIFO store buffer. The buffer drains into a single-port word array in cycles when no load occupies the port.
- Loads forward from the youngest matching buffered store.

---
 rtl/dmem_store_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// Memory-stage data memory: stores are posted into a FIFO store buffer that drains into a
// single-port word array whenever no load claims the port; loads forward from the youngest match.
module dmem_store_buffer #(
    parameter int MEM_WORDS = 64,
    parameter int SB_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    input  logic                      we,
    input  logic                      re,
    output logic [31:0]               rdata,
    output logic                      sb_full,
    output logic                      sb_empty,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_ovf
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ent_idx   [SB_DEPTH];
    logic [31:0]      ent_data  [SB_DEPTH];
    logic [SB_DEPTH-1:0] ent_valid;
    logic [31:0]      mem       [MEM_WORDS];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] fwd_pos;
    logic             drain;
    logic             accept;
    logic             unused_addr_bits;

    // Upper address bits alias onto the same word on purpose.
    assign idx              = addr[IDX_W+1:2];
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

    always_comb begin
        drain  = ~re & (count != '0);
        accept = we & ((count < CNT_W'(SB_DEPTH)) | drain);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            sb_ovf    <= 1'b0;
        end else begin
            if (drain) begin
                head            <= head + PTR_W'(1);
                ent_valid[head] <= 1'b0;
            end
            // When full, head == tail; this later assignment keeps the freshly accepted entry valid.
            if (accept) begin
                tail            <= tail + PTR_W'(1);
                ent_valid[tail] <= 1'b1;
            end
            if (we && !accept) begin
                sb_ovf <= 1'b1;
            end
            case ({accept, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry payloads and the word array carry no reset; validity lives in ent_valid alone.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_idx[tail]  <= idx;
            ent_data[tail] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && drain) begin
            mem[ent_idx[head]] <= ent_data[head];
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rdata   = '0;
        fwd_pos = '0;
        if (re) begin
            rdata = mem[idx];
            // Scan oldest to youngest so the youngest match is the one left standing.
            for (int k = 0; k < SB_DEPTH; k++) begin
                fwd_pos = head + PTR_W'(k);
                if (ent_valid[fwd_pos] && (ent_idx[fwd_pos] == idx)) begin
                    rdata = ent_data[fwd_pos];
                end
            end
        end
    end

    assign sb_count = count;
    assign sb_full  = (count == CNT_W'(SB_DEPTH));
    assign sb_empty = (count == '0);

endmodule
